// File: rtl/uart_word_rx_if.sv
// rtl/uart_word_rx_if.sv - word-side handshake bundle between uart_word_rx and its consumer
interface uart_word_rx_if #(
    parameter int WORD_BYTES = 20
) ();
    logic [WORD_BYTES*8-1:0] data;
    logic                    rdy;
    logic                    rdy_clr;
    logic                    frame_err;
    logic                    overrun;

    modport master (
        output data,
        output rdy,
        output frame_err,
        output overrun,
        input  rdy_clr
    );

    modport slave (
        input  data,
        input  rdy,
        input  frame_err,
        input  overrun,
        output rdy_clr
    );
endinterface

// File: rtl/uart_word_rx.sv
// rtl/uart_word_rx.sv - oversampled UART receiver assembling WORD_BYTES bytes per word; UART_WORD_RX_PARITY_EN adds even parity
module uart_word_rx #(
    parameter int WORD_BYTES = 20,
    parameter int OVERSAMPLE = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_en,
    input  logic               rx,
    uart_word_rx_if.master     word_if
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(WORD_BYTES + 1);
    localparam int DW = WORD_BYTES * 8;
    localparam logic [TW-1:0] LP_TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] LP_TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] LP_WORD_FULL = BW'(WORD_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_WORD_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_rx_meta;
    logic            r_rx_sync;
    logic [TW-1:0]   r_tick;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic [BW-1:0]   r_byte;
    logic [DW-1:0]   r_word;
    logic [DW-1:0]   r_data;
    logic            r_rdy;
    logic            r_frame_err;
    logic            r_overrun;

    logic            w_rx;
    logic            w_start_det;
    logic            w_tick_clr;
    logic            w_tick_inc;
    logic            w_data_sample;
    logic            w_stop_ok;
    logic            w_stop_bad;
    logic            w_par_fail;
    logic            w_byte_keep;
    logic            w_complete;
    logic [DW-1:0]   w_word_next;

    assign w_rx       = r_rx_sync;
    assign w_complete = (r_byte == LP_WORD_FULL);

    // New byte enters at bit 0 so the first byte of the word ends up in the top byte
    generate
        if (WORD_BYTES == 1) begin : g_one_byte
            assign w_word_next = r_shift;
        end else begin : g_multi_byte
            assign w_word_next = {r_word[DW-9:0], r_shift};
        end
    endgenerate

`ifdef UART_WORD_RX_PARITY_EN
    logic w_par_check;
    logic r_par_bad;
    assign w_par_fail  = w_par_check && (w_rx != (^r_shift));
    assign w_byte_keep = w_stop_ok && !r_par_bad;
`else
    assign w_par_fail  = 1'b0;
    assign w_byte_keep = w_stop_ok;
`endif

    // Two-flop synchronizer on the asynchronous serial line; idles high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-tick strobes; nothing moves on cycles without sample_en
    always_comb begin
        w_state_next  = r_state;
        w_start_det   = 1'b0;
        w_tick_clr    = 1'b0;
        w_tick_inc    = 1'b0;
        w_data_sample = 1'b0;
        w_stop_ok     = 1'b0;
        w_stop_bad    = 1'b0;
`ifdef UART_WORD_RX_PARITY_EN
        w_par_check   = 1'b0;
`endif
        if (sample_en) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rx) begin
                        w_start_det  = 1'b1;
                        w_tick_clr   = 1'b1;
                        w_state_next = S_START;
                    end
                end
                S_START: begin
                    if (r_tick == LP_TICK_HALF) begin
                        w_tick_clr   = 1'b1;
                        w_state_next = w_rx ? S_IDLE : S_DATA;
                    end else begin
                        w_tick_inc = 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_tick == LP_TICK_LAST) begin
                        w_tick_clr    = 1'b1;
                        w_data_sample = 1'b1;
                        if (r_bit == 3'd7) begin
`ifdef UART_WORD_RX_PARITY_EN
                            w_state_next = S_PARITY;
`else
                            w_state_next = S_STOP;
`endif
                        end
                    end else begin
                        w_tick_inc = 1'b1;
                    end
                end
`ifdef UART_WORD_RX_PARITY_EN
                S_PARITY: begin
                    if (r_tick == LP_TICK_LAST) begin
                        w_tick_clr   = 1'b1;
                        w_par_check  = 1'b1;
                        w_state_next = S_STOP;
                    end else begin
                        w_tick_inc = 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (r_tick == LP_TICK_LAST) begin
                        w_tick_clr   = 1'b1;
                        w_stop_ok    = w_rx;
                        w_stop_bad   = !w_rx;
                        w_state_next = S_IDLE;
                    end else begin
                        w_tick_inc = 1'b1;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // Bit timing and serial-to-parallel shift (LSB first)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            if (w_tick_clr) begin
                r_tick <= '0;
            end else if (w_tick_inc) begin
                r_tick <= r_tick + 1'b1;
            end
            if (w_start_det) begin
                r_bit <= '0;
            end else if (w_data_sample) begin
                r_bit <= r_bit + 1'b1;
            end
            if (w_data_sample) begin
                r_shift <= {w_rx, r_shift[7:1]};
            end
        end
    end

`ifdef UART_WORD_RX_PARITY_EN
    // A parity miss poisons the current byte so the stop-bit path drops it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_bad <= 1'b0;
        end else if (w_start_det) begin
            r_par_bad <= 1'b0;
        end else if (w_par_fail) begin
            r_par_bad <= 1'b1;
        end
    end
`endif

    // Word assembly, completion hand-off and sticky status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte      <= '0;
            r_word      <= '0;
            r_data      <= '0;
            r_rdy       <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_complete) begin
                r_byte <= '0;
            end else if (w_stop_bad || w_par_fail) begin
                r_byte <= '0;
            end else if (w_byte_keep) begin
                r_byte <= r_byte + 1'b1;
                r_word <= w_word_next;
            end

            if (w_complete) begin
                if (!r_rdy || word_if.rdy_clr) begin
                    r_data <= r_word;
                    r_rdy  <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (word_if.rdy_clr) begin
                r_rdy       <= 1'b0;
                r_frame_err <= 1'b0;
                r_overrun   <= 1'b0;
            end

            // An error event wins over a same-cycle acknowledge
            if (w_stop_bad || w_par_fail) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    assign word_if.data      = r_data;
    assign word_if.rdy       = r_rdy;
    assign word_if.frame_err = r_frame_err;
    assign word_if.overrun   = r_overrun;
endmodule

// File: tb/tb_uart_word_rx.sv
// tb/tb_uart_word_rx.sv - directed self-checking bench for uart_word_rx
module tb_uart_word_rx;
    localparam int WB = 20;
    localparam int OS = 16;
`ifdef UART_WORD_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic sample_en;
    logic rx;
    int   n_vectors = 0;
    int   n_miscompares = 0;

    logic [7:0] w1_bytes [WB] = '{8'h67, 8'h45, 8'h23, 8'h01, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h98, 8'hBA,
                                  8'hDC, 8'hFE, 8'h10, 8'h32, 8'h54, 8'h76, 8'hC3, 8'hD2, 8'hE1, 8'hF0};
    logic [7:0] w2_bytes [WB] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99,
                                  8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h0F, 8'h1E, 8'h2D, 8'h3C};
    logic [7:0] a5_bytes [WB] = '{default: 8'hA5};

    localparam logic [159:0] EXP_W1 = 160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0;
    localparam logic [159:0] EXP_W2 = 160'h00112233445566778899AABBCCDDEEFF0F1E2D3C;
    localparam logic [159:0] EXP_A5 = 160'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5;

    uart_word_rx_if #(.WORD_BYTES(WB)) u_if ();

    uart_word_rx #(
        .WORD_BYTES (WB),
        .OVERSAMPLE (OS)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .rx        (rx),
        .word_if   (u_if)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vectors++;
        assert (obs === exp) else begin
            n_miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_vectors++;
        assert (obs === exp) else begin
            n_miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (OS) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        @(posedge clk);
        #1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_WORD_RX_PARITY_EN
        drive_bit(^b);
`endif
        drive_bit(stop_v);
        rx = 1'b1;
    endtask

`ifdef UART_WORD_RX_PARITY_EN
    task automatic send_bad_parity_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(~(^b));
        drive_bit(1'b1);
        rx = 1'b1;
    endtask
`endif

    task automatic send_bytes(input logic [7:0] t [WB], input int n);
        for (int i = 0; i < n; i++) send_byte(t[i], 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rdy_clr();
        @(posedge clk);
        #1 u_if.rdy_clr = 1'b1;
        @(posedge clk);
        #1 u_if.rdy_clr = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        sample_en    = 1'b1;
        rx           = 1'b1;
        u_if.rdy_clr = 1'b0;
        #2;
        chkw("reset_data", u_if.data, '0);
        chk1("reset_rdy", u_if.rdy, 1'b0);
        chk1("reset_frame_err", u_if.frame_err, 1'b0);
        chk1("reset_overrun", u_if.overrun, 1'b0);
        idle(3);
        rst_n = 1'b1;
        idle(5);

        // one clean word
        send_bytes(w1_bytes, WB);
        idle(4);
        chk1("w1_rdy", u_if.rdy, 1'b1);
        chkw("w1_data", u_if.data, EXP_W1);
        chk1("w1_frame_err", u_if.frame_err, 1'b0);
        chk1("w1_overrun", u_if.overrun, 1'b0);
        pulse_rdy_clr();
        chk1("w1_clr_rdy", u_if.rdy, 1'b0);
        chkw("w1_clr_data_held", u_if.data, EXP_W1);

        // short low glitch on idle line
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(40);
        chk1("glitch_rdy", u_if.rdy, 1'b0);
        chk1("glitch_frame_err", u_if.frame_err, 1'b0);

        // bad stop bit on byte 5, then a full word of A5
        send_bytes(w2_bytes, 4);
        send_byte(8'h44, 1'b0);
        idle(2 * OS);
        chk1("badstop_frame_err", u_if.frame_err, 1'b1);
        chk1("badstop_rdy", u_if.rdy, 1'b0);
        send_bytes(a5_bytes, WB);
        idle(4);
        chk1("a5_rdy", u_if.rdy, 1'b1);
        chkw("a5_data", u_if.data, EXP_A5);
        chk1("a5_frame_err_sticky", u_if.frame_err, 1'b1);
        pulse_rdy_clr();
        chk1("a5_clr_frame_err", u_if.frame_err, 1'b0);
        chk1("a5_clr_rdy", u_if.rdy, 1'b0);

        // two words with no acknowledge: second is dropped
        send_bytes(w1_bytes, WB);
        send_bytes(w2_bytes, WB);
        idle(4);
        chk1("ovr_overrun", u_if.overrun, 1'b1);
        chk1("ovr_rdy", u_if.rdy, 1'b1);
        chkw("ovr_data_w1", u_if.data, EXP_W1);
        pulse_rdy_clr();
        chk1("ovr_clr_rdy", u_if.rdy, 1'b0);
        chk1("ovr_clr_overrun", u_if.overrun, 1'b0);
        chk1("ovr_clr_frame_err", u_if.frame_err, 1'b0);

        // acknowledge landing in the completion cycle of word 2
        send_bytes(w1_bytes, WB);
        idle(2);
        chk1("ackc_w1_rdy", u_if.rdy, 1'b1);
        chkw("ackc_w1_data", u_if.data, EXP_W1);
        send_bytes(w2_bytes, WB - 1);
        fork
            send_byte(w2_bytes[WB-1], 1'b1);
            begin
                repeat (16 * FRAME_BITS - 4) @(posedge clk);
                #1 u_if.rdy_clr = 1'b1;
                @(posedge clk);
                #1 u_if.rdy_clr = 1'b0;
            end
        join
        idle(2);
        chk1("ackc_rdy", u_if.rdy, 1'b1);
        chkw("ackc_data_w2", u_if.data, EXP_W2);
        chk1("ackc_overrun", u_if.overrun, 1'b0);

        // reset mid-word, then a fresh word
        send_bytes(w1_bytes, 10);
        rst_n = 1'b0;
        #1;
        chkw("rst_data", u_if.data, '0);
        chk1("rst_rdy", u_if.rdy, 1'b0);
        chk1("rst_frame_err", u_if.frame_err, 1'b0);
        chk1("rst_overrun", u_if.overrun, 1'b0);
        idle(3);
        rst_n = 1'b1;
        idle(3);
        send_bytes(w1_bytes, WB);
        idle(4);
        chk1("post_rst_rdy", u_if.rdy, 1'b1);
        chkw("post_rst_data", u_if.data, EXP_W1);
        chk1("post_rst_frame_err", u_if.frame_err, 1'b0);

`ifdef UART_WORD_RX_PARITY_EN
        pulse_rdy_clr();
        send_bad_parity_byte(8'h5A);
        idle(4);
        chk1("parity_frame_err", u_if.frame_err, 1'b1);
        chk1("parity_rdy", u_if.rdy, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
